// File: rtl/imm_ext_pipe_pkg.sv
// Shared opcode constants and immediate extension modes
// for the decode-stage immediate extender.
package imm_ext_pipe_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'd0,
    IMM_ZERO   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

endpackage

// File: rtl/imm_ext_pipe_core.sv
// Combinational opcode-to-mode decode and immediate extension.
// Usable unregistered by decode as well as ahead of the skid buffer.
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [IMM_W-1:0]  imm_i,
  output imm_mode_e         mode_o,
  output logic [DATA_W-1:0] ext_o
);

  logic [5:0]        op6;
  logic              is_zero;
  logic              is_upper;
  logic              is_branch;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] uext;

  assign op6 = 6'(op_i);

  assign is_zero = (op6 == OP_ANDI) ||
                   (op6 == OP_ORI)  ||
                   (op6 == OP_XORI);

  assign is_upper = (op6 == OP_LUI);

  assign is_branch = (op6 == OP_BEQ)  ||
                     (op6 == OP_BNE)  ||
                     (op6 == OP_BGTZ) ||
                     (op6 == OP_BLEZ) ||
                     (op6 == OP_REGIMM);

  assign sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign zext = {{(DATA_W-IMM_W){1'b0}}, imm_i};
  assign uext = {imm_i, {(DATA_W-IMM_W){1'b0}}};

  always_comb begin
    mode_o = IMM_SIGN;
    unique case (1'b1)
      is_zero:   mode_o = IMM_ZERO;
      is_upper:  mode_o = IMM_UPPER;
      is_branch: mode_o = IMM_BRANCH;
      default:   mode_o = IMM_SIGN;
    endcase
  end

  always_comb begin
    ext_o = sext;
    unique case (mode_o)
      IMM_ZERO:   ext_o = zext;
      IMM_UPPER:  ext_o = uext;
      IMM_BRANCH: ext_o = sext << 2;
      default:    ext_o = sext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry skid buffer,
// flush support and valid/ready handshakes on both sides.
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [OP_W-1:0]   in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_mode,
  output logic [TAG_W-1:0]  out_tag
);

  imm_mode_e         new_mode;
  logic [DATA_W-1:0] new_imm;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_imm_q,   m_imm_d;
  imm_mode_e         m_mode_q,  m_mode_d;
  logic [TAG_W-1:0]  m_tag_q,   m_tag_d;

  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_imm_q,   s_imm_d;
  imm_mode_e         s_mode_q,  s_mode_d;
  logic [TAG_W-1:0]  s_tag_q,   s_tag_d;

  logic accept;
  logic emit;

  imm_ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_core (
    .op_i   (in_op),
    .imm_i  (in_imm),
    .mode_o (new_mode),
    .ext_o  (new_imm)
  );

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = !s_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign emit     = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_mode_d  = m_mode_q;
    m_tag_d   = m_tag_q;
    s_valid_d = s_valid_q;
    s_imm_d   = s_imm_q;
    s_mode_d  = s_mode_q;
    s_tag_d   = s_tag_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || emit)) begin
      m_valid_d = 1'b1;
      m_imm_d   = new_imm;
      m_mode_d  = new_mode;
      m_tag_d   = in_tag;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_imm_d   = new_imm;
      s_mode_d  = new_mode;
      s_tag_d   = in_tag;
    end else if (emit && s_valid_q) begin
      m_valid_d = 1'b1;
      m_imm_d   = s_imm_q;
      m_mode_d  = s_mode_q;
      m_tag_d   = s_tag_q;
      s_valid_d = 1'b0;
    end else if (emit) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_mode_q  <= IMM_SIGN;
      m_tag_q   <= '0;
      s_valid_q <= 1'b0;
      s_imm_q   <= '0;
      s_mode_q  <= IMM_SIGN;
      s_tag_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_mode_q  <= m_mode_d;
      m_tag_q   <= m_tag_d;
      s_valid_q <= s_valid_d;
      s_imm_q   <= s_imm_d;
      s_mode_q  <= s_mode_d;
      s_tag_q   <= s_tag_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_imm   = m_imm_q;
  assign out_mode  = m_mode_q;
  assign out_tag   = m_tag_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed-vector bench for imm_ext_pipe.
// Inputs change 1ns after each rising edge; outputs are checked there.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [5:0]  in_op;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  out_mode;
  logic [7:0]  out_tag;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  imm_ext_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_mode  (out_mode),
    .out_tag   (out_tag)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op,
                       input logic [15:0] imm,
                       input logic [7:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    in_tag   = tag;
  endtask

  logic [5:0]  v_op   [6];
  logic [15:0] v_imm  [6];
  logic [31:0] v_exp  [6];
  logic [1:0]  v_mode [6];

  initial begin
    v_op[0] = 6'b001100; v_imm[0] = 16'h8001;
    v_exp[0] = 32'h00008001; v_mode[0] = 2'd1;
    v_op[1] = 6'b001111; v_imm[1] = 16'h1234;
    v_exp[1] = 32'h12340000; v_mode[1] = 2'd2;
    v_op[2] = 6'b000100; v_imm[2] = 16'hFFFF;
    v_exp[2] = 32'hFFFFFFFC; v_mode[2] = 2'd3;
    v_op[3] = 6'b000101; v_imm[3] = 16'h0004;
    v_exp[3] = 32'h00000010; v_mode[3] = 2'd3;
    v_op[4] = 6'b001101; v_imm[4] = 16'hFFFF;
    v_exp[4] = 32'h0000FFFF; v_mode[4] = 2'd1;
    v_op[5] = 6'b100011; v_imm[5] = 16'hFFFC;
    v_exp[5] = 32'hFFFFFFFC; v_mode[5] = 2'd0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_imm = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_mode", 32'(out_mode), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Single ADDI, one cycle latency
    drive(6'b001000, 16'h8001, 8'h11);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFF8001);
    chk("addi_mode", 32'(out_mode), 32'd0);
    chk("addi_tag", 32'(out_tag), 32'h11);
    tick();
    chk("addi_drain", 32'(out_valid), 32'd0);

    // Back-to-back stream, one result per cycle
    for (int i = 0; i < 6; i++) begin
      drive(v_op[i], v_imm[i], 8'(8'h20 + i));
      tick();
      chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b_imm%0d", i), out_imm, v_exp[i]);
      chk($sformatf("b2b_mode%0d", i), 32'(out_mode), 32'(v_mode[i]));
      chk($sformatf("b2b_tag%0d", i), 32'(out_tag), 32'(8'h20 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: tag1 in M, tag2 in S, tag3 held upstream
    out_ready = 1'b0;
    drive(6'b001000, 16'h0001, 8'd1);
    tick();
    chk("bp_t1", 32'(out_tag), 32'd1);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    drive(6'b001000, 16'h0002, 8'd2);
    tick();
    chk("bp_rdy2", 32'(in_ready), 32'd0);
    chk("bp_hold_tag", 32'(out_tag), 32'd1);
    drive(6'b001000, 16'h0003, 8'd3);
    tick();
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    chk("bp_stable_imm", out_imm, 32'h00000001);
    chk("bp_stable_tag", 32'(out_tag), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_out2_tag", 32'(out_tag), 32'd2);
    chk("bp_out2_imm", out_imm, 32'h00000002);
    tick();
    in_valid = 1'b0;
    chk("bp_out3_tag", 32'(out_tag), 32'd3);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Flush with both entries full
    out_ready = 1'b0;
    drive(6'b001000, 16'h00AA, 8'hA1);
    tick();
    drive(6'b001000, 16'h00BB, 8'hA2);
    tick();
    chk("fl_full_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(6'b001101, 16'h00F0, 8'h44);
    tick();
    in_valid = 1'b0;
    chk("fl_next_valid", 32'(out_valid), 32'd1);
    chk("fl_next_imm", out_imm, 32'h000000F0);
    chk("fl_next_tag", 32'(out_tag), 32'h44);
    tick();
    chk("fl_next_drain", 32'(out_valid), 32'd0);

    // Flush coinciding with accept discards the entry
    drive(6'b001000, 16'h0055, 8'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flacc_valid0", 32'(out_valid), 32'd0);
    tick();
    chk("flacc_valid1", 32'(out_valid), 32'd0);

    // Reset mid-stream with both entries full
    out_ready = 1'b0;
    drive(6'b001111, 16'hBEEF, 8'h61);
    tick();
    drive(6'b001111, 16'hCAFE, 8'h62);
    tick();
    chk("mrst_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_imm", out_imm, 32'd0);
    chk("mrst_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("mrst_no_ghost", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Decode-stage immediate extender, parametrised and registered. It extends an IMM_W-bit instruction immediate to DATA_W bits using an opcode-selected mode: sign, zero, LUI-upper or branch-offset. It sits between instruction decode and the D/E pipeline register. A valid/ready handshake with a 2-entry skid buffer lets execute-stage backpressure stall it without dropping or duplicating immediates. A flush input kills in-flight entries on branch mispredicts and exceptions.

Parameters:
IMM_W, 16, width of the raw immediate field.
DATA_W, 32, width of the extended result; must be ≥ IMM_W+2.
OP_W, 6, width of the opcode field.
TAG_W, 8, width of the sideband tag (PC low bits / ROB id) carried alongside the immediate.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  kill all buffered entries.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  block can accept this cycle.
in_imm  in  IMM_W  raw immediate.
in_op  in  OP_W  opcode (opD).
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  out_imm/out_tag/out_mode valid.
out_ready  in  1  downstream accepts.
out_imm  out  DATA_W  extended immediate.
out_mode  out  2  applied mode: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH.
out_tag  out  TAG_W  tag matching out_imm.

Behaviour:
- Mode decode (combinational on in_op, using the shared opcode defines):
  - ANDI, ORI, XORI → ZERO.
  - LUI → UPPER.
  - BEQ, BNE, BGTZ, BLEZ, REGIMM → BRANCH.
  - All others → SIGN.
- Extension (DATA_W bits, computed before the register):
  - SIGN: {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}.
  - ZERO: {(DATA_W-IMM_W){0}, imm}.
  - UPPER: imm placed at [DATA_W-1 : DATA_W-IMM_W], zeros below. If DATA_W < 2*IMM_W, the low DATA_W-IMM_W bits are zero.
  - BRANCH: sign-extend imm to DATA_W, then shift left 2; upper bits shifted out are discarded.
- Storage: main register (M) drives the outputs; skid register (S) holds one extra entry.
- in_ready = !S.valid && !rst. This is registered state only, with no combinational path from out_ready.
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- Per-cycle update, unless flush or rst:
  - Accept with M empty, or with Emit: the new entry loads into M.
  - Accept with M full and no Emit: the new entry loads into S.
  - Emit with S full: S moves to M and S clears.
  - Emit with S empty and no Accept: M clears.
- Latency: 1 cycle from Accept to out_valid when the pipe is empty. Throughput: 1 per cycle while out_ready=1.
- Outputs stay stable while out_valid=1 && out_ready=0.
- flush (sampled at the clock edge):
  - M.valid and S.valid clear next cycle.
  - An input accepted in the same cycle is discarded.
  - in_ready is unaffected by flush in that cycle.
- Flush takes priority over Accept and Emit. rst takes priority over flush.
- Reset values: out_valid=0, out_imm=0, out_mode=0, out_tag=0, S cleared; in_ready=0 while rst=1.
- rst asserted mid-stream drops all entries; there are no partial results.
- Ordering: entries leave in acceptance order, with no reordering or duplication.

Decomposition:
- Shared package/header: mode encodings (IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_BRANCH) and the opcode constants from the existing defines header. Do not redefine them locally.
- One natural sub-module: imm_ext_core. It is purely combinational (op, imm → mode, ext) and instantiated once ahead of the skid logic, so decode can reuse it unregistered.

Test Plan:
- Reset, then in_valid=1 op=ADDI(001000) imm=0x8001, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFF8001, mode=0.
- Back-to-back ANDI 0x8001, LUI 0x1234, BEQ 0xFFFF, BNE 0x0004 with out_ready=1 → outputs in order: 0x00008001, 0x12340000, 0xFFFFFFFC, 0x00000010; one per cycle; tags preserved.
- out_ready=0 for 3 cycles while feeding tags 1, 2, 3:
  - tag1 sits in M, tag2 in S, and in_ready drops to 0.
  - tag3 is held upstream; out_imm stays stable.
  - Release → tags emitted 1, 2, 3 with no loss.
- M and S both full, then flush=1 with in_valid=0 → next cycle out_valid=0, in_ready=1. The following accept emits normally.
- flush=1 and Accept in the same cycle → accepted entry is never emitted.
- rst asserted mid-stream with both entries full → next cycle out_valid=0, out_imm=0; in_ready=0 during rst and 1 the cycle after.
